free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have rst, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have flush, input, 1, synchronous pipeline flush; same cycle the reorder buffer is cleared.
REQ-004 SHALL have freeze_front, input, 1, front-end stall; blocks allocation.
REQ-005 SHALL have alloc_req, input, 1, rename group of three requests three physical registers.
REQ-006 SHALL have Pw_alloc_x/y/z, output, 5 each, allocated physical registers; valid when alloc_ok.
REQ-007 SHALL have alloc_ok, output, 1, allocation occurs this cycle.
REQ-008 SHALL have empty_FL, output, 1, fewer than three free registers.
REQ-009 SHALL have free_x/y/z, input, 1 each, retire slot valid (RegWr_x/y/z from reorder buffer).
REQ-010 SHALL have Pw_free_x/y/z, input, 5 each, overwritten physical register released at retire (Pw_retire_x/y/z).
REQ-011 SHALL have free_cnt, output, 6, number of free registers held.

Function
REQ-012 SHALL hold free registers in a 32-slot circular buffer of 5-bit entries; 6-bit pointers head, tail, arch_head (bit 5 = wrap).
REQ-013 SHALL drive Pw_alloc_x/y/z = slot[head], slot[head+1], slot[head+2] (mod 32), combinationally.
REQ-014 SHALL assert alloc_ok = alloc_req & !freeze_front & !empty_FL & !flush.
REQ-015 SHALL advance head by 3 on the clock edge where alloc_ok is 1.
REQ-016 SHALL compute free count n_free as valid prefix only: 0 if !free_x, 1 if free_x&!free_y, 2 if free_x&free_y&!free_z, else 3; non-prefix bits ignored.
REQ-017 SHALL write Pw_free_x/y/z to slot[tail], slot[tail+1], slot[tail+2] for the first n_free slots and advance tail by n_free, regardless of freeze_front or flush.
REQ-018 SHALL advance arch_head by n_free each cycle (each retire commits one earlier allocation).
REQ-019 SHALL on flush load head with arch_head + n_free (same-cycle retires included); tail unaffected.
REQ-020 SHALL compute free_cnt = tail - head (6-bit) and empty_FL = (free_cnt < 3); same-cycle frees SHALL NOT bypass into empty_FL.
REQ-021 SHALL process simultaneous alloc and free in one cycle: free_cnt_next = free_cnt - 3 + n_free.
REQ-022 SHALL wrap all pointer arithmetic modulo 64; slot index = pointer[4:0].

Reset
REQ-023 SHALL on rst low set slot[i] = i+8 for i = 0..23, slot[24..31] = 0, head = 0, arch_head = 0, tail = 24.
REQ-024 SHALL after reset present Pw_alloc_x/y/z = 8/9/10, free_cnt = 24, empty_FL = 0, alloc_ok = alloc_req & !freeze_front.
REQ-025 SHALL let reset override flush, alloc and free in the same cycle.

Configuration
REQ-026 SHALL, with FREE_LIST_CHECK_EN defined, add output fl_err (1 bit, reset 0) set sticky when free_cnt_next > 24 or an alloc would underflow; without it, no fl_err port and no checking logic.

Structure
REQ-027 SHALL take N_PREG=32, N_AREG=8, PREG_W=5, AREG_W=3 and typedef preg_t from the shared core package.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 Reset, alloc_req=1 three cycles -> Pw_alloc 8/9/10, 11/12/13, 14/15/16; free_cnt 24->15.
REQ-030 Alloc 8 groups (24 regs), no frees -> empty_FL=1, free_cnt=0, alloc_ok=0 with alloc_req=1.
REQ-031 free_cnt=0; free_x/y/z=1 with Pw_free 3/5/7 -> next cycle empty_FL=0, Pw_alloc 3/5/7.
REQ-032 Alloc 2 groups, retire 3 (free 0/1/2), then flush -> head = arch_head = 3, Pw_alloc 11/12/13, free_cnt 24.
REQ-033 Same-cycle alloc_req and free_x only (Pw_free=4) at free_cnt=3 -> alloc_ok=1, free_cnt_next=1, empty_FL=1.
REQ-034 free_x=0, free_y=1 -> n_free=0, tail unchanged; with FREE_LIST_CHECK_EN, extra frees past 24 -> fl_err=1 held until reset.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared core constants and types for the rename free list.
// Also holds the retire-slot prefix counter used when releasing registers.
package free_list_pkg;

  localparam int N_PREG       = 32;
  localparam int N_AREG       = 8;
  localparam int PREG_W       = 5;
  localparam int AREG_W       = 3;
  localparam int PTR_W        = 6;
  localparam int N_RESET_FREE = N_PREG - N_AREG;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  // Only a contiguous run of valid slots starting at x is honoured.
  function automatic logic [1:0] prefix_cnt(input logic x, input logic y, input logic z);
    logic [1:0] n;
    casez ({x, y, z})
      3'b0??:  n = 2'd0;
      3'b10?:  n = 2'd1;
      3'b110:  n = 2'd2;
      3'b111:  n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers: three allocations and up to three releases per cycle.
// Define FREE_LIST_CHECK_EN to add the sticky fl_err overflow/underflow flag.
module free_list
  import free_list_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       freeze_front,
  input  logic       alloc_req,
  output preg_t      Pw_alloc_x,
  output preg_t      Pw_alloc_y,
  output preg_t      Pw_alloc_z,
  output logic       alloc_ok,
  output logic       empty_FL,
  input  logic       free_x,
  input  logic       free_y,
  input  logic       free_z,
  input  preg_t      Pw_free_x,
  input  preg_t      Pw_free_y,
  input  preg_t      Pw_free_z,
  output logic [5:0] free_cnt
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic       fl_err
`endif
);

  ptr_t        r_head;
  ptr_t        r_tail;
  ptr_t        r_arch;
  preg_t       r_slot [N_PREG];

  logic [1:0]  w_nfree;
  logic        w_ok;
  logic        w_empty;
  ptr_t        w_cnt;
  ptr_t        w_head_nxt;
  ptr_t        w_tail_nxt;
  ptr_t        w_arch_nxt;
  ptr_t        w_cnt_nxt;
  logic [4:0]  w_ridx [3];
  logic [4:0]  w_widx [3];
  preg_t       w_wdat [3];

  assign w_cnt    = r_tail - r_head;
  assign w_empty  = (w_cnt < 6'd3);
  assign w_ok     = alloc_req & ~freeze_front & ~w_empty & ~flush;
  assign w_nfree  = prefix_cnt(free_x, free_y, free_z);

  assign free_cnt = w_cnt;
  assign empty_FL = w_empty;
  assign alloc_ok = w_ok;

  assign w_wdat[0] = Pw_free_x;
  assign w_wdat[1] = Pw_free_y;
  assign w_wdat[2] = Pw_free_z;

  // Read and write slot indices for the three lanes, wrapping within the 32-entry ring.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_ridx[k] = r_head[4:0] + 5'(k);
      w_widx[k] = r_tail[4:0] + 5'(k);
    end
  end

  assign Pw_alloc_x = r_slot[w_ridx[0]];
  assign Pw_alloc_y = r_slot[w_ridx[1]];
  assign Pw_alloc_z = r_slot[w_ridx[2]];

  // Next pointers; a flush rewinds head to the committed point including this cycle's retires.
  always_comb begin
    w_tail_nxt = r_tail + {4'd0, w_nfree};
    w_arch_nxt = r_arch + {4'd0, w_nfree};
    if (flush) begin
      w_head_nxt = w_arch_nxt;
    end else if (w_ok) begin
      w_head_nxt = r_head + 6'd3;
    end else begin
      w_head_nxt = r_head;
    end
    w_cnt_nxt = w_tail_nxt - w_head_nxt;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= 6'd0;
      r_arch <= 6'd0;
      r_tail <= 6'(N_RESET_FREE);
    end else begin
      r_head <= w_head_nxt;
      r_arch <= w_arch_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  // Slot storage: reset seeds the non-architectural registers, retires append at tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PREG; i++) begin
        r_slot[i] <= (i < N_RESET_FREE) ? PREG_W'(i + N_AREG) : '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < w_nfree) begin
          r_slot[w_widx[k]] <= w_wdat[k];
        end else begin
          r_slot[w_widx[k]] <= r_slot[w_widx[k]];
        end
      end
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic r_err;

  // Sticky error: more free registers than can exist, or an allocation from too few.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((w_cnt_nxt > 6'(N_RESET_FREE)) || (w_ok && w_empty)) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign fl_err = r_err;
`else
  logic w_unused;
  assign w_unused = ^w_cnt_nxt;
`endif

endmodule
